// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the ibus/dbus memory port arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_t;
    typedef enum logic [1:0] {NONE, I, D} arb_owner_t;

    // MSIZE encoding of a 4-byte word, used for every instruction fetch
    localparam logic [2:0] MSIZE4 = 3'b010;

    function automatic int strbW(input int dataW);
        return dataW / 8;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_grant.sv
// Grant selector for the ibus/dbus arbiter.
// With ARB_ROUND_ROBIN_EN the requester that did not win the last grant wins a tie.
module arb_grant
    import mem_bus_arbiter_pkg::*;
(
    input  logic       iValid,
    input  logic       dValid,
    input  arb_owner_t lastOwner,
    output arb_owner_t grant
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        grant = NONE;
        if (iValid && dValid)
            grant = (lastOwner == D) ? I : D;
        else if (dValid)
            grant = D;
        else if (iValid)
            grant = I;
    end
`else
    // dbus always wins: the memory stage is older than fetch
    always_comb begin
        grant = NONE;
        if (dValid)
            grant = D;
        else if (iValid)
            grant = I;
    end

    logic unusedLast;
    assign unusedLast = ^lastOwner;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch (ibus) and data (dbus), one transaction at a time.
// Optional ARB_ROUND_ROBIN_EN swaps fixed dbus priority for alternating grants on a tie.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                i_valid,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_addr_ok,
    output logic                i_data_ok,
    output logic [DATA_W-1:0]   i_data,
    input  logic                d_valid,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [2:0]          d_size,
    input  logic [DATA_W/8-1:0] d_strobe,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_addr_ok,
    output logic                d_data_ok,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [2:0]          m_size,
    output logic [DATA_W/8-1:0] m_strobe,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_addr_ok,
    input  logic                m_data_ok,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int STRB_W = strbW(DATA_W);

    arb_state_t          state;
    arb_owner_t          owner;
    arb_owner_t          grant;
    arb_owner_t          lastOwner;
    logic [ADDR_W-1:0]   addrQ;
    logic [2:0]          sizeQ;
    logic [STRB_W-1:0]   strobeQ;
    logic [DATA_W-1:0]   wdataQ;
    logic                addrHs;
    logic                dataDone;

`ifdef ARB_ROUND_ROBIN_EN
    logic lastD;
    assign lastOwner = lastD ? D : I;
`else
    assign lastOwner = I;
`endif

    arb_grant uGrant (
        .iValid    (i_valid),
        .dValid    (d_valid),
        .lastOwner (lastOwner),
        .grant     (grant)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            owner   <= NONE;
            addrQ   <= '0;
            sizeQ   <= '0;
            strobeQ <= '0;
            wdataQ  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            lastD   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant != NONE) begin
                        owner <= grant;
                        state <= ADDR;
`ifdef ARB_ROUND_ROBIN_EN
                        lastD <= (grant == D);
`endif
                        if (grant == D) begin
                            addrQ   <= d_addr;
                            sizeQ   <= d_size;
                            strobeQ <= d_strobe;
                            wdataQ  <= d_wdata;
                        end else begin
                            addrQ   <= i_addr;
                            sizeQ   <= MSIZE4;
                            strobeQ <= '0;
                            wdataQ  <= '0;
                        end
                    end
                end
                ADDR: begin
                    if (m_addr_ok) begin
                        state <= m_data_ok ? IDLE : DATA;
                        if (m_data_ok)
                            owner <= NONE;
                    end
                end
                DATA: begin
                    if (m_data_ok) begin
                        state <= IDLE;
                        owner <= NONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    owner <= NONE;
                end
            endcase
        end
    end

    // Handshakes are decoded from state so an async reset clears them at once
    assign addrHs   = (state == ADDR) && m_addr_ok;
    assign dataDone = m_data_ok && ((state == DATA) || addrHs);

    assign m_valid  = (state == ADDR);
    assign m_addr   = addrQ;
    assign m_size   = sizeQ;
    assign m_strobe = strobeQ;
    assign m_wdata  = wdataQ;

    assign i_addr_ok = addrHs && (owner == I);
    assign d_addr_ok = addrHs && (owner == D);
    assign i_data_ok = dataDone && (owner == I);
    assign d_data_ok = dataDone && (owner == D);
    assign i_data    = i_data_ok ? m_rdata : '0;
    assign d_rdata   = d_data_ok ? m_rdata : '0;

endmodule
